// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants used by the fetch path.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP      = 32'd4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/instr_prefetch_unit_if.sv
// Memory request/response, core delivery and redirect signals of the prefetch unit.
interface instr_prefetch_unit_if;
  import mips_pkg::*;

  logic               mem_req_valid;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_req_ready;
  logic               mem_rsp_valid;
  logic [INSTR_W-1:0] mem_rsp_data;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_ready;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               flushing;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output out_valid, out_instr, out_pc,
    input  out_ready, redirect_valid, redirect_pc,
    output flushing
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  out_valid, out_instr, out_pc,
    output out_ready, redirect_valid, redirect_pc,
    input  flushing
  );

endinterface

// File: rtl/instr_prefetch_unit_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush dominates push/pop.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Sequential instruction prefetcher: credit-limited requests, in-order responses, redirect flush.
module instr_prefetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR
) (
  input logic                   clk,
  input logic                   reset,
  instr_prefetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t       state, state_next;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  rsp_pc;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      discard_cnt, discard_next;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        credit_used;
  logic               fifo_full, fifo_empty;
  logic               req_fire, rsp_drop, push, pop;
  fetch_entry_t       entry_in, head;

  // Stale requests still hold credit until their responses come back.
  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(outstanding);
  assign bus.mem_req_valid = !reset && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign bus.mem_req_addr  = fetch_pc;
  assign req_fire = bus.mem_req_valid && bus.mem_req_ready;

  assign rsp_drop = bus.redirect_valid || (discard_cnt != '0);
  assign push     = bus.mem_rsp_valid && !rsp_drop;
  assign pop      = !fifo_empty && bus.out_ready && !bus.redirect_valid;
  assign entry_in = '{pc: rsp_pc, instr: bus.mem_rsp_data};

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (entry_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_instr = fifo_empty ? '0 : head.instr;
  assign bus.out_pc    = fifo_empty ? '0 : head.pc;
  assign bus.flushing  = (state == ST_FLUSH);

  always_comb begin
    state_next   = state;
    discard_next = discard_cnt;
    if (bus.redirect_valid) begin
      // A response landing in the redirect cycle is dropped here, not counted as stale.
      discard_next = outstanding - CW'(bus.mem_rsp_valid);
      state_next   = (discard_next != '0) ? ST_FLUSH : ST_RUN;
    end else if (state == ST_FLUSH && bus.mem_rsp_valid) begin
      discard_next = discard_cnt - CW'(1);
      if (discard_next == '0) state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      discard_cnt <= '0;
    end else begin
      state       <= state_next;
      discard_cnt <= discard_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
    end else begin
      if (bus.redirect_valid) begin
        fetch_pc <= word_align(bus.redirect_pc);
        rsp_pc   <= word_align(bus.redirect_pc);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (push)     rsp_pc   <= rsp_pc + PC_STEP;
      end
      unique case ({req_fire, bus.mem_rsp_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  a_rsp_has_request: assert property (@(posedge clk) disable iff (reset)
    bus.mem_rsp_valid |-> (outstanding != '0));
  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    push |-> !fifo_full);

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Randomized bench for instr_prefetch_unit against a queue-based model of the fetch rules.
module tb_instr_prefetch_unit;
  import mips_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {logic [31:0] addr; int unsigned due;} mreq_t;
  typedef struct {logic [31:0] addr; bit stale;} pend_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  instr_prefetch_unit_if bus();

  instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  mreq_t        mem_q[$];
  pend_t        m_pend[$];
  fetch_entry_t m_fifo[$];
  logic [31:0]  m_pc;
  int unsigned  cyc = 0;
  int unsigned  accepts = 0;
  int unsigned  outs = 0;
  int unsigned  lat_lo = 1, lat_hi = 1, ready_pct = 100, oready_pct = 100, redir_pct = 0;
  bit           force_redir = 0;
  logic [31:0]  force_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit pct(input int unsigned p);
    return ($urandom_range(99) < p);
  endfunction

  function automatic bit any_stale();
    foreach (m_pend[i]) if (m_pend[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cfg(input int unsigned llo, input int unsigned lhi, input int unsigned rdy,
                     input int unsigned ordy, input int unsigned rdr);
    lat_lo = llo; lat_hi = lhi; ready_pct = rdy; oready_pct = ordy; redir_pct = rdr;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
    bus.out_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = '0;
    force_redir = 0;
    #1;
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_flushing", bus.flushing, 0);
    mem_q.delete(); m_pend.delete(); m_fifo.delete();
    m_pc = RST_PC; accepts = 0; outs = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step();
    bit rv, ordy, rdy, rspv, exp_req, acc, pop;
    logic [31:0] rp;
    pend_t p;
    @(posedge clk);
    #1;
    cyc++;
    rdy  = pct(ready_pct);
    ordy = pct(oready_pct);
    if (force_redir) begin
      rv = 1; rp = force_pc; force_redir = 0;
    end else begin
      rv = pct(redir_pct);
      case ($urandom_range(3))
        0: rp = $urandom;
        1: rp = 32'hFFFF_FFE0 | 32'($urandom_range(31));
        2: rp = 32'($urandom_range(1023));
        default: rp = 32'h0000_4000 + 32'($urandom_range(63));
      endcase
    end
    rspv = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    bus.mem_req_ready  = rdy;
    bus.out_ready      = ordy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.mem_rsp_valid  = rspv;
    if (rspv) begin
      bus.mem_rsp_data = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      bus.mem_rsp_data = $urandom;
    end
    #1;

    exp_req = !rv && (m_fifo.size() + m_pend.size() < DEPTH);
    chk("mem_req_valid", bus.mem_req_valid, exp_req);
    if (exp_req) chk("mem_req_addr", bus.mem_req_addr, m_pc);
    chk("out_valid", bus.out_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) begin
      chk("out_pc", bus.out_pc, m_fifo[0].pc);
      chk("out_instr", bus.out_instr, m_fifo[0].instr);
    end
    chk("flushing", bus.flushing, any_stale());

    if (bus.mem_req_valid && bus.mem_req_ready) begin
      mem_q.push_back('{addr: bus.mem_req_addr, due: cyc + $urandom_range(lat_hi, lat_lo)});
      accepts++;
    end
    if (bus.out_valid) outs++;

    acc = exp_req && rdy;
    pop = (m_fifo.size() != 0) && ordy && !rv;
    if (pop) void'(m_fifo.pop_front());
    if (rspv && m_pend.size() != 0) begin
      p = m_pend.pop_front();
      if (!rv && !p.stale) m_fifo.push_back('{pc: p.addr, instr: mem_word(p.addr)});
    end
    if (rv) begin
      m_fifo.delete();
      foreach (m_pend[i]) m_pend[i].stale = 1'b1;
      m_pc = rp & ~32'd3;
    end
    if (acc) begin
      m_pend.push_back('{addr: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic wait_out(input int max_cycles, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (bus.out_valid) begin
        ok = 1;
        return;
      end
    end
  endtask

  initial begin
    bit ok;
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
    bus.out_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = '0;
    m_pc = RST_PC;

    // Cold start, latency 1
    do_reset();
    cfg(1, 1, 100, 100, 0);
    step(); chk("cold_req_valid", bus.mem_req_valid, 1); chk("cold_addr0", bus.mem_req_addr, 32'h0);
    step(); chk("cold_addr1", bus.mem_req_addr, 32'h4); chk("cold_no_bypass", bus.out_valid, 0);
    step(); chk("cold_first_valid", bus.out_valid, 1); chk("cold_first_pc", bus.out_pc, 32'h0);
    chk("cold_first_instr", bus.out_instr, 32'h5A5A_0F0F);
    step(); chk("cold_second_pc", bus.out_pc, 32'h4);
    step(); chk("cold_third_pc", bus.out_pc, 32'h8);

    // Back-pressure fills the FIFO, then drains in order
    do_reset();
    cfg(1, 1, 100, 0, 0);
    repeat (8) step();
    chk("fill_accepts", accepts, 4);
    chk("fill_req_blocked", bus.mem_req_valid, 0);
    chk("fill_out_valid", bus.out_valid, 1);
    oready_pct = 100;
    step(); chk("drain_pc0", bus.out_pc, 32'h0);
    step(); chk("drain_pc1", bus.out_pc, 32'h4);
    chk("drain_resume_valid", bus.mem_req_valid, 1); chk("drain_resume_addr", bus.mem_req_addr, 32'h10);
    step(); chk("drain_pc2", bus.out_pc, 32'h8);
    step(); chk("drain_pc3", bus.out_pc, 32'hC);

    // Redirect with three stale requests in flight
    do_reset();
    cfg(5, 5, 100, 100, 0);
    repeat (3) step();
    force_redir = 1; force_pc = 32'h100;
    step(); chk("rd3_no_req_in_redirect", bus.mem_req_valid, 0);
    step(); chk("rd3_flushing", bus.flushing, 1); chk("rd3_new_addr", bus.mem_req_addr, 32'h100);
    repeat (3) step();
    chk("rd3_still_flushing", bus.flushing, 1);
    step(); chk("rd3_flush_done", bus.flushing, 0);
    wait_out(20, ok);
    chk("rd3_out_timeout", ok, 1);
    chk("rd3_out_pc", bus.out_pc, 32'h100);
    chk("rd3_out_instr", bus.out_instr, 32'h6D23_BE0F);

    // Redirect coinciding with a response, unaligned target
    do_reset();
    cfg(2, 2, 100, 100, 0);
    repeat (2) step();
    force_redir = 1; force_pc = 32'h203;
    step();
    step(); chk("rdc_flushing", bus.flushing, 1); chk("rdc_aligned_addr", bus.mem_req_addr, 32'h200);
    step(); chk("rdc_flush_done", bus.flushing, 0);
    wait_out(20, ok);
    chk("rdc_out_timeout", ok, 1);
    chk("rdc_out_pc", bus.out_pc, 32'h200);

    // Address wrap at the top of memory
    do_reset();
    cfg(1, 1, 100, 100, 0);
    force_redir = 1; force_pc = 32'hFFFF_FFFC;
    step(); chk("wrap_no_flush", bus.flushing, 0);
    step(); chk("wrap_addr_top", bus.mem_req_addr, 32'hFFFF_FFFC);
    step(); chk("wrap_addr_zero", bus.mem_req_addr, 32'h0);

    // Sustained throughput with latency 2
    do_reset();
    cfg(2, 2, 100, 100, 0);
    repeat (10) step();
    outs = 0;
    repeat (20) step();
    chk("throughput", outs, 20);

    // Reset while requests are outstanding and the FIFO holds entries
    do_reset();
    cfg(3, 3, 100, 0, 0);
    repeat (6) step();
    chk("midrst_pre_valid", bus.out_valid, 1);
    chk("midrst_pre_pc", bus.out_pc, 32'h0);
    do_reset();
    cfg(1, 1, 100, 100, 0);
    step(); chk("midrst_restart_valid", bus.mem_req_valid, 1);
    chk("midrst_restart_addr", bus.mem_req_addr, RST_PC);

    // Randomized traffic
    do_reset(); cfg(1, 3, 70, 70, 5);  repeat (1500) step();
    do_reset(); cfg(1, 6, 50, 40, 8);  repeat (1500) step();
    do_reset(); cfg(1, 2, 90, 90, 2);  repeat (1500) step();
    do_reset(); cfg(3, 8, 80, 30, 10); repeat (1500) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
